// File: rtl/chaos_sbox_gen_if.sv
// Control, seed and table-read bundle of the chaotic S-box generator.
interface chaos_sbox_gen_if #(
  parameter int unsigned SBOX_W = 8,
  parameter int unsigned FRAC_W = 16
);
  logic              start;
  logic [FRAC_W-1:0] seed;
  logic [SBOX_W-1:0] rd_addr;
  logic              inv_sel;
  logic [SBOX_W-1:0] rd_data;
  logic              busy;
  logic              done_sbox;

  modport master (
    output start, seed, rd_addr, inv_sel,
    input  rd_data, busy, done_sbox
  );

  modport slave (
    input  start, seed, rd_addr, inv_sel,
    output rd_data, busy, done_sbox
  );
endinterface

// File: rtl/chaos_sbox_gen.sv
// Chaotic S-box generator: fixed-point logistic map feeding a linear-probe
// bijection builder that fills a forward table and its inverse.
module chaos_sbox_gen #(
  parameter int unsigned SBOX_W  = 8,
  parameter int unsigned FRAC_W  = 16,
  parameter int unsigned DISCARD = 64
) (
  input  logic            clk,
  input  logic            rst,
  chaos_sbox_gen_if.slave bus
);
  localparam int unsigned DEPTH  = 1 << SBOX_W;
  localparam int unsigned IDX_W  = SBOX_W + 1;
  localparam int unsigned DISC_W = $clog2(DISCARD + 1);
  localparam int unsigned COMP_W = FRAC_W + 1;
  localparam int unsigned PROD_W = 2 * FRAC_W + 1;

  typedef enum logic [2:0] {IDLE, WARM, ITER, CHECK, DONE} state_t;

  state_t            state;
  logic [FRAC_W-1:0] x;
  logic [FRAC_W-1:0] seed_r;
  logic [SBOX_W-1:0] cand;
  logic [IDX_W-1:0]  idx;
  logic [DISC_W-1:0] disc_cnt;
  logic [DEPTH-1:0]  used;
  logic              busy;
  logic              done_sbox;
  logic [SBOX_W-1:0] rd_data;

  logic [SBOX_W-1:0] sbox_mem [DEPTH];
  logic [SBOX_W-1:0] inv_mem  [DEPTH];

  logic [COMP_W-1:0] comp_c;
  logic [PROD_W-1:0] prod_c;
  logic [PROD_W-1:0] shift_c;
  logic [FRAC_W-1:0] x_next_c;
  logic [FRAC_W-1:0] seed_g_c;
  logic [SBOX_W-1:0] cand_top_c;
  logic              wr_c;

  // Logistic map step: x*(1-x)*4 in Q0.FRAC_W, saturated, zero re-seeded.
  always_comb begin
    comp_c     = {1'b1, {FRAC_W{1'b0}}} - {1'b0, x};
    prod_c     = PROD_W'(x) * PROD_W'(comp_c);
    shift_c    = prod_c >> (FRAC_W - 2);
    x_next_c   = shift_c[FRAC_W-1:0];
    if (|shift_c[PROD_W-1:FRAC_W]) begin
      x_next_c = '1;
    end
    if (x_next_c == '0) begin
      x_next_c = seed_r;
    end
    cand_top_c = x_next_c[FRAC_W-1 -: SBOX_W];
    seed_g_c   = (bus.seed == '0) ? FRAC_W'(1) : bus.seed;
    wr_c       = (state == CHECK) && !used[cand];
  end

  // Generation FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      seed_r    <= '0;
      cand      <= '0;
      idx       <= '0;
      disc_cnt  <= '0;
      used      <= '0;
      busy      <= 1'b0;
      done_sbox <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            x         <= seed_g_c;
            seed_r    <= seed_g_c;
            idx       <= '0;
            disc_cnt  <= '0;
            used      <= '0;
            busy      <= 1'b1;
            done_sbox <= 1'b0;
            state     <= WARM;
          end
        end
        WARM: begin
          x <= x_next_c;
          if (disc_cnt == DISC_W'(DISCARD - 1)) begin
            state <= ITER;
          end else begin
            disc_cnt <= disc_cnt + DISC_W'(1);
          end
        end
        ITER: begin
          x     <= x_next_c;
          cand  <= cand_top_c;
          state <= CHECK;
        end
        CHECK: begin
          if (!used[cand]) begin
            used[cand] <= 1'b1;
            idx        <= idx + IDX_W'(1);
            state      <= (idx == IDX_W'(DEPTH - 1)) ? DONE : ITER;
          end else begin
            // Linear probe to the next free symbol guarantees a bijection.
            cand <= cand + SBOX_W'(1);
          end
        end
        DONE: begin
          busy      <= 1'b0;
          done_sbox <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Table writes; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (wr_c && !rst) begin
      sbox_mem[idx[SBOX_W-1:0]] <= cand;
      inv_mem[cand]             <= idx[SBOX_W-1:0];
    end
  end

  // Registered read port, active regardless of FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= bus.inv_sel ? inv_mem[bus.rd_addr] : sbox_mem[bus.rd_addr];
    end
  end

  assign bus.rd_data   = rd_data;
  assign bus.busy      = busy;
  assign bus.done_sbox = done_sbox;
endmodule

// File: tb/tb_chaos_sbox_gen.sv
// Directed bench for chaos_sbox_gen: 8-bit and 4-bit instances against a
// behavioural model of the logistic-map / linear-probe table builder.
module tb_chaos_sbox_gen;
  localparam int BOUND_A = 64 + 513 + 32640;
  localparam int BOUND_B = 161 + 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chaos_sbox_gen_if #(.SBOX_W(8), .FRAC_W(16)) a ();
  chaos_sbox_gen_if #(.SBOX_W(4), .FRAC_W(12)) b ();

  chaos_sbox_gen #(.SBOX_W(8), .FRAC_W(16), .DISCARD(64)) dut_a (
    .clk(clk), .rst(rst), .bus(a.slave)
  );
  chaos_sbox_gen #(.SBOX_W(4), .FRAC_W(12), .DISCARD(8)) dut_b (
    .clk(clk), .rst(rst), .bus(b.slave)
  );

  int checks = 0;
  int errors = 0;

  int         exp_sbox [256];
  int         exp_inv  [256];
  int         exp_cyc;
  logic [7:0] got_sbox [256];
  logic [7:0] got_inv  [256];
  logic [7:0] snap_a   [256];
  logic [7:0] snap_0   [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic longint mstep(input longint xv, input longint s, input int fw);
    longint p, y, full;
    full = (longint'(1) << fw) - 1;
    p = xv * ((longint'(1) << fw) - xv);
    y = p >> (fw - 2);
    if (y > full) y = full;
    if (y == 0) y = s;
    return y;
  endfunction

  task automatic model(input int w, input int fw, input int disc, input longint sd);
    longint xv, s;
    int n, cand;
    bit used [256];
    n = 1 << w;
    s = (sd == 0) ? 1 : sd;
    xv = s;
    for (int i = 0; i < 256; i++) used[i] = 1'b0;
    exp_cyc = disc;
    for (int i = 0; i < disc; i++) xv = mstep(xv, s, fw);
    for (int i = 0; i < n; i++) begin
      xv = mstep(xv, s, fw);
      cand = int'(xv >> (fw - w));
      exp_cyc += 2;
      while (used[cand]) begin
        cand = (cand + 1) % n;
        exp_cyc++;
      end
      used[cand] = 1'b1;
      exp_sbox[i] = cand;
      exp_inv[cand] = i;
    end
    exp_cyc += 1;
  endtask

  task automatic run_a(input logic [15:0] sd, input bit guard_pulse, output int cyc);
    a.seed = sd;
    a.start = 1'b1;
    tick();
    a.start = 1'b0;
    chk("a_busy_rise", 64'(a.busy), 64'd1);
    chk("a_done_clear", 64'(a.done_sbox), 64'd0);
    cyc = 0;
    while (a.done_sbox !== 1'b1 && cyc < BOUND_A) begin
      if (guard_pulse && cyc == 20) begin
        a.seed = 16'h1111;
        a.start = 1'b1;
      end else begin
        a.start = 1'b0;
      end
      tick();
      cyc++;
    end
    a.start = 1'b0;
    chk("a_done_timeout", 64'(a.done_sbox), 64'd1);
    chk("a_busy_fall", 64'(a.busy), 64'd0);
  endtask

  task automatic read_a();
    for (int i = 0; i < 256; i++) begin
      a.rd_addr = 8'(i);
      a.inv_sel = 1'b0;
      tick();
      got_sbox[i] = a.rd_data;
    end
    for (int i = 0; i < 256; i++) begin
      a.rd_addr = 8'(i);
      a.inv_sel = 1'b1;
      tick();
      got_inv[i] = a.rd_data;
    end
  endtask

  task automatic read_b();
    for (int i = 0; i < 16; i++) begin
      b.rd_addr = 4'(i);
      b.inv_sel = 1'b0;
      tick();
      got_sbox[i] = 8'(b.rd_data);
    end
    for (int i = 0; i < 16; i++) begin
      b.rd_addr = 4'(i);
      b.inv_sel = 1'b1;
      tick();
      got_inv[i] = 8'(b.rd_data);
    end
  endtask

  // Model match, bijection and inverse consistency of the got_* tables.
  task automatic cmp_model(input string tag, input int n);
    int mis_f, mis_i, dup, bad_inv;
    int cnt [256];
    mis_f = 0; mis_i = 0; dup = 0; bad_inv = 0;
    for (int i = 0; i < 256; i++) cnt[i] = 0;
    for (int i = 0; i < n; i++) begin
      if (got_sbox[i] !== 8'(exp_sbox[i])) mis_f++;
      if (got_inv[i] !== 8'(exp_inv[i])) mis_i++;
      if (!$isunknown(got_sbox[i])) cnt[got_sbox[i]]++;
    end
    for (int v = 0; v < n; v++) if (cnt[v] != 1) dup++;
    for (int i = 0; i < n; i++) begin
      if ($isunknown(got_sbox[i]) || got_inv[got_sbox[i]] !== 8'(i)) bad_inv++;
    end
    chk({tag, "_fwd_vs_model"}, 64'(mis_f), 64'd0);
    chk({tag, "_inv_vs_model"}, 64'(mis_i), 64'd0);
    chk({tag, "_bijection"}, 64'(dup), 64'd0);
    chk({tag, "_inv_of_fwd"}, 64'(bad_inv), 64'd0);
  endtask

  task automatic cmp_snap(input string tag, input bit use0);
    int mis;
    mis = 0;
    for (int i = 0; i < 256; i++) begin
      if (got_sbox[i] !== (use0 ? snap_0[i] : snap_a[i])) mis++;
    end
    chk(tag, 64'(mis), 64'd0);
  endtask

  initial begin
    int cyc;
    int idle_bad;

    rst = 1'b1;
    a.start = 1'b0; a.seed = '0; a.rd_addr = '0; a.inv_sel = 1'b0;
    b.start = 1'b0; b.seed = '0; b.rd_addr = '0; b.inv_sel = 1'b0;
    tick();
    tick();
    chk("rst_busy_a", 64'(a.busy), 64'd0);
    chk("rst_done_a", 64'(a.done_sbox), 64'd0);
    chk("rst_rd_a", 64'(a.rd_data), 64'd0);
    chk("rst_busy_b", 64'(b.busy), 64'd0);
    chk("rst_rd_b", 64'(b.rd_data), 64'd0);
    rst = 1'b0;

    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (a.busy !== 1'b0 || a.done_sbox !== 1'b0) idle_bad++;
    end
    chk("idle_no_change", 64'(idle_bad), 64'd0);

    // First generation with the reference seed.
    model(8, 16, 64, 64'h3A5C);
    run_a(16'h3A5C, 1'b0, cyc);
    chk("a_cycles_3a5c", 64'(cyc), 64'(exp_cyc));
    chk("a_cycles_bound", 64'(cyc <= 64 + 513 + 32640), 64'd1);
    read_a();
    cmp_model("s3a5c", 256);
    for (int i = 0; i < 256; i++) snap_a[i] = got_sbox[i];

    // Seed zero is treated as seed one.
    model(8, 16, 64, 64'h0000);
    run_a(16'h0000, 1'b0, cyc);
    chk("a_cycles_0000", 64'(cyc), 64'(exp_cyc));
    read_a();
    cmp_model("s0000", 256);
    for (int i = 0; i < 256; i++) snap_0[i] = got_sbox[i];
    run_a(16'h0001, 1'b0, cyc);
    read_a();
    cmp_snap("seed0_eq_seed1", 1'b1);

    run_a(16'h3A5C, 1'b0, cyc);
    read_a();
    cmp_snap("repeat_3a5c", 1'b0);

    // start pulse while busy must be ignored.
    model(8, 16, 64, 64'h3A5C);
    run_a(16'h3A5C, 1'b1, cyc);
    chk("guard_cycles", 64'(cyc), 64'(exp_cyc));
    read_a();
    cmp_snap("guard_table", 1'b0);

    // Abort mid-generation, then regenerate.
    a.seed = 16'h3A5C;
    a.start = 1'b1;
    tick();
    a.start = 1'b0;
    repeat (199) tick();
    chk("mid_busy_before", 64'(a.busy), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", 64'(a.busy), 64'd0);
    chk("mid_rst_done", 64'(a.done_sbox), 64'd0);
    rst = 1'b0;
    tick();
    chk("mid_idle_after", 64'(a.busy), 64'd0);
    run_a(16'h3A5C, 1'b0, cyc);
    read_a();
    cmp_snap("restart_table", 1'b0);

    // Small instance.
    model(4, 12, 8, 64'h9A3);
    b.seed = 12'h9A3;
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    chk("b_busy_rise", 64'(b.busy), 64'd1);
    cyc = 0;
    while (b.done_sbox !== 1'b1 && cyc < BOUND_B) begin
      tick();
      cyc++;
    end
    chk("b_done_timeout", 64'(b.done_sbox), 64'd1);
    chk("b_busy_fall", 64'(b.busy), 64'd0);
    chk("b_cycles_model", 64'(cyc), 64'(exp_cyc));
    chk("b_cycles_range", 64'(cyc >= 41 && cyc <= 161), 64'd1);
    read_b();
    cmp_model("s9a3", 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/chaos_sbox_gen.md
# chaos_sbox_gen

Parametrised chaotic S-box generator: iterates a fixed-point logistic map from a seed and builds a bijective SBOX_W-bit substitution table plus its inverse. Sits beside the pixel diffusion/confusion datapath inside `top`. It generalises the fixed 8-bit S-box stage with a configurable width, a transient-discard count, an inverse table, and a read port for the cipher core. It signals completion on `done_sbox`.

## Interface
Parameters:
- SBOX_W, 8, S-box input/output width; table depth 2^SBOX_W (legal 4..8)
- FRAC_W, 16, logistic-map state width, unsigned Q0.FRAC_W fraction (FRAC_W ≥ SBOX_W+4)
- DISCARD, 64, map iterations dropped after start (transient removal, ≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to regenerate tables; ignored while busy
- seed  in  FRAC_W  initial map state, sampled on accepted start
- rd_addr  in  SBOX_W  table read address
- inv_sel  in  1  0: read forward S-box, 1: read inverse S-box
- rd_data  out  SBOX_W  registered read data
- busy  out  1  high from accepted start until done_sbox rises
- done_sbox  out  1  level; high when both tables are complete, cleared by start or rst

## Operation
- Map: x' = (4·x·(2^FRAC_W − x)) >> FRAC_W, computed as product >> (FRAC_W−2), saturated to 2^FRAC_W−1. If x' == 0, x' is replaced by the sampled seed. A seed of 0 is loaded as 1.
- Candidate: cand = x'[FRAC_W−1 -: SBOX_W].
- Storage: sbox[2^SBOX_W], inv[2^SBOX_W] (not reset), used bitmap of 2^SBOX_W flops, idx counter (SBOX_W+1 bits), discard counter.
- FSM states:
  - IDLE: on start, x ← seed (0→1), idx ← 0, used ← all 0, busy ← 1, done_sbox ← 0, go to WARM.
  - WARM: one map iteration per cycle. After DISCARD iterations, go to ITER.
  - ITER: x ← x', cand ← top bits of x', go to CHECK.
  - CHECK: if !used[cand], write sbox[idx] ← cand, inv[cand] ← idx, set used[cand], idx ← idx+1. If idx was 2^SBOX_W−1, go to DONE; otherwise go to ITER. If used[cand], set cand ← cand+1 (mod 2^SBOX_W) and stay in CHECK (linear probe).
  - DONE: busy ← 0, done_sbox ← 1, go to IDLE.
- Probing guarantees termination and a bijection.
- Results are deterministic for a given (seed, parameters).
- start while busy is ignored.
- start in IDLE with done_sbox=1 restarts generation; done_sbox drops the next cycle.
- Read port: rd_data ← inv_sel ? inv[rd_addr] : sbox[rd_addr] every cycle, independent of FSM state. While busy, entries not yet written are stale or undefined.

## Timing
- Reset values: busy=0, done_sbox=0, rd_data=0, state=IDLE, idx=0, used=0. Table contents are not cleared.
- rst mid-generation aborts on the next edge: busy=0, done_sbox=0. Tables are left partially written. The next start regenerates them fully.
- Start accepted at edge T: busy=1 and done_sbox=0 from T+1.
- Generation cycles: WARM (DISCARD) + per entry (ITER 1 + CHECK 1 + probes p_i) + DONE 1.
  - Minimum: DISCARD + 2·2^SBOX_W + 1.
  - Upper bound: minimum + 2^SBOX_W·(2^SBOX_W−1)/2.
- done_sbox rises on the same edge that busy falls.
- Read latency: 1 cycle. rd_addr/inv_sel at edge T gives rd_data valid after edge T+1.
- Simultaneous start and rst: rst wins.

## Test plan
- Reset: hold rst 2 cycles → busy=0, done_sbox=0, rd_data=0. start=0 for 100 cycles → no change.
- Bijection, SBOX_W=8, seed=16'h3A5C: start → done_sbox within the bound (≤ 64+513+32640 cycles). Read all 256 forward entries → each value 0..255 appears exactly once. inv[sbox[i]]==i for all i. Match the bit-exact reference model.
- Determinism and seed guard: run seed=16'h0000 and seed=16'h0001 → identical tables. Repeat seed=16'h3A5C → identical to first run.
- Busy guard: pulse start with seed=16'h1111 during generation of 16'h3A5C → ignored. Final table equals the 16'h3A5C result.
- Reset mid-op: assert rst at cycle 200 of a run → busy=0 and done_sbox=0 next cycle. Restart with 16'h3A5C → table matches the uninterrupted run.
- Small instance, SBOX_W=4, FRAC_W=12, DISCARD=8: seed=12'h9A3 → 16-entry bijection matches model. Cycle count lies in [41, 161].
